// File: rtl/video_capture_pkg.sv
// Shared types and constants for the video_capture slice: FSM states, FIFO word layout
// and default display-mode-3 geometry.
package video_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    CAPTURE,
    DROP
  } cap_state_e;

  localparam int MODE3_H_RES = 672;
  localparam int MODE3_V_RES = 384;

  // FIFO word layout, MSB first: {sof, eol, r, g, b}
  function automatic int cap_word_w(input int bpc);
    return 3 * bpc + 2;
  endfunction

endpackage

// File: rtl/video_capture_fifo_sync.sv
// Single-clock FIFO with registered occupancy and a registered read port that holds
// its word until accepted; rd_valid doubles as the not-empty indication.
module fifo_sync #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    occ;
  logic             push, pop, load, mem_empty, mem_rd, bypass, mem_wr;

  // occ counts memory plus the output register, so DEPTH words fit in total
  assign full      = (occ == CNT_FULL);
  assign push      = wr_en && !full;
  assign pop       = rd_valid && rd_ready;
  assign load      = !rd_valid || pop;
  assign mem_empty = (wr_ptr == rd_ptr);
  assign mem_rd    = load && !mem_empty;
  assign bypass    = load && mem_empty && push;
  assign mem_wr    = push && !bypass;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      occ <= occ + CW'(push) - CW'(pop);
      if (mem_wr) wr_ptr <= wr_ptr + 1'b1;
      if (mem_rd) begin
        rd_data  <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
        rd_valid <= 1'b1;
      end else if (bypass) begin
        rd_data  <= wr_data;
        rd_valid <= 1'b1;
      end else if (load) begin
        rd_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/video_capture.sv
// Frame-aligned pixel capture into a valid/ready stream.
// Optional macro CAPTURE_CHECK_EN adds per-frame geometry checking on geom_err.
module video_capture
  import video_capture_pkg::*;
#(
  parameter int BPC        = 8,
  parameter int CORDW      = 16,
  parameter int H_RES      = MODE3_H_RES,
  parameter int V_RES      = MODE3_V_RES,
  parameter int FIFO_DEPTH = 1024
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix,
  input  logic                    cap_en,
  input  logic signed [CORDW-1:0] vid_x,
  input  logic signed [CORDW-1:0] vid_y,
  input  logic                    vid_de,
  input  logic                    vid_frame,
  input  logic [BPC-1:0]          vid_r,
  input  logic [BPC-1:0]          vid_g,
  input  logic [BPC-1:0]          vid_b,
  output logic [3*BPC-1:0]        cap_data,
  output logic                    cap_sof,
  output logic                    cap_eol,
  output logic                    cap_valid,
  input  logic                    cap_ready,
  output logic                    cap_busy,
  output logic                    cap_overflow,
  output logic [15:0]             drop_count,
  output logic [15:0]             frame_count,
  output logic                    geom_err
);

  localparam int WW = cap_word_w(BPC);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || H_RES < 1 || V_RES < 1)
  begin : g_bad_cfg
    $error("video_capture: FIFO_DEPTH must be a power of two >= 2 and resolution nonzero");
  end

  logic signed [CORDW-1:0] r_x, r_y;
  logic                    r_de, r_frame, r_en;
  logic [3*BPC-1:0]        r_rgb;

  cap_state_e state, next_state, eff_state;
  logic       fifo_full, fifo_wr, pix_drop, frame_start, overflow_hit;
  logic       pix_sof, pix_eol;
  logic [WW-1:0] wr_word, rd_word;

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_x     <= '0;
      r_y     <= '0;
      r_de    <= 1'b0;
      r_frame <= 1'b0;
      r_en    <= 1'b0;
      r_rgb   <= '0;
    end else begin
      r_x     <= vid_x;
      r_y     <= vid_y;
      r_de    <= vid_de;
      r_frame <= vid_frame;
      r_en    <= cap_en;
      r_rgb   <= {vid_r, vid_g, vid_b};
    end
  end

  assign pix_sof = (r_x == '0) && (r_y == '0);
  assign pix_eol = (r_x == CORDW'(H_RES - 1));
  assign wr_word = {pix_sof, pix_eol, r_rgb};

  always_ff @(posedge clk_pix) begin
    if (rst_pix) state <= IDLE;
    else         state <= next_state;
  end

  // eff_state applies the frame-strobe transition first, so a pixel arriving with
  // the strobe is handled by the state of the frame it opens.
  always_comb begin
    eff_state = state;
    if (r_frame && state != IDLE) eff_state = r_en ? CAPTURE : IDLE;
    next_state = eff_state;
    case (state)
      IDLE:    if (r_en) next_state = ARM;
      ARM:     if (!r_frame && !r_en) next_state = IDLE;
      default: ;
    endcase
    if (eff_state == CAPTURE && r_de && fifo_full) next_state = DROP;
  end

  always_comb begin
    frame_start  = r_frame && (state != IDLE) && r_en;
    fifo_wr      = (eff_state == CAPTURE) && r_de;
    overflow_hit = fifo_wr && fifo_full;
    pix_drop     = overflow_hit || ((eff_state == DROP) && r_de);
  end

  assign cap_busy = (state != IDLE);

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      frame_count  <= '0;
      drop_count   <= '0;
      cap_overflow <= 1'b0;
    end else begin
      if (frame_start) frame_count <= frame_count + 16'd1;
      if (pix_drop && drop_count != '1) drop_count <= drop_count + 16'd1;
      if (overflow_hit) cap_overflow <= 1'b1;
    end
  end

  fifo_sync #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WW)
  ) u_fifo (
    .clk      (clk_pix),
    .rst      (rst_pix),
    .wr_en    (fifo_wr),
    .wr_data  (wr_word),
    .full     (fifo_full),
    .rd_data  (rd_word),
    .rd_valid (cap_valid),
    .rd_ready (cap_ready)
  );

  assign cap_sof  = rd_word[WW-1];
  assign cap_eol  = rd_word[WW-2];
  assign cap_data = rd_word[3*BPC-1:0];

`ifdef CAPTURE_CHECK_EN
  localparam int FRAME_PIX = H_RES * V_RES;
  localparam int PW        = $clog2(FRAME_PIX) + 1;
  localparam logic signed [CORDW-1:0] Y_LIM = CORDW'(V_RES);

  logic [PW-1:0] pix_cnt;

  // Counter restarts at each accepted strobe; a pixel riding on the strobe is counted
  // in the new frame. Frames that ended in DROP leave state != CAPTURE and go unchecked.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      pix_cnt  <= '0;
      geom_err <= 1'b0;
    end else begin
      if (r_frame && state == CAPTURE && pix_cnt != PW'(FRAME_PIX)) geom_err <= 1'b1;
      if (fifo_wr && pix_eol && r_y >= Y_LIM) geom_err <= 1'b1;
      if (frame_start) pix_cnt <= PW'(fifo_wr);
      else if (fifo_wr && pix_cnt != '1) pix_cnt <= pix_cnt + 1'b1;
    end
  end
`else
  assign geom_err = 1'b0;
`endif

endmodule

// File: tb/tb_video_capture.sv
// Scoreboard bench for video_capture on a 4x2 frame with a 4-entry FIFO.
`timescale 1ns/1ps
module tb_video_capture;

  localparam int BPC   = 8;
  localparam int CORDW = 16;
  localparam int H_RES = 4;
  localparam int V_RES = 2;
  localparam int DEPTH = 4;

  logic                    clk_pix = 1'b0;
  logic                    rst_pix;
  logic                    cap_en;
  logic signed [CORDW-1:0] vid_x, vid_y;
  logic                    vid_de, vid_frame;
  logic [BPC-1:0]          vid_r, vid_g, vid_b;
  logic [3*BPC-1:0]        cap_data;
  logic                    cap_sof, cap_eol, cap_valid, cap_ready;
  logic                    cap_busy, cap_overflow, geom_err;
  logic [15:0]             drop_count, frame_count;

  always #5 clk_pix = ~clk_pix;

  video_capture #(
    .BPC        (BPC),
    .CORDW      (CORDW),
    .H_RES      (H_RES),
    .V_RES      (V_RES),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_pix      (clk_pix),
    .rst_pix      (rst_pix),
    .cap_en       (cap_en),
    .vid_x        (vid_x),
    .vid_y        (vid_y),
    .vid_de       (vid_de),
    .vid_frame    (vid_frame),
    .vid_r        (vid_r),
    .vid_g        (vid_g),
    .vid_b        (vid_b),
    .cap_data     (cap_data),
    .cap_sof      (cap_sof),
    .cap_eol      (cap_eol),
    .cap_valid    (cap_valid),
    .cap_ready    (cap_ready),
    .cap_busy     (cap_busy),
    .cap_overflow (cap_overflow),
    .drop_count   (drop_count),
    .frame_count  (frame_count),
    .geom_err     (geom_err)
  );

  typedef struct packed {
    logic             sof;
    logic             eol;
    logic [3*BPC-1:0] data;
  } word_t;

  word_t       exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          cyc      = 0;
  int          mode     = 0;  // 0: ready high, 1: ready toggles, 2: ready low
  int          de_cyc   = 0;
  bit          lat_arm  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  word_t cur, prev_word, exp_w;
  bit    prev_stall = 1'b0;

  always @(negedge clk_pix) begin
    cur = {cap_sof, cap_eol, cap_data};
    if (rst_pix) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(cap_valid), 32'd1);
        check("hold_word", 32'(cur), 32'(prev_word));
      end
      if (lat_arm && cap_valid) begin
        check("latency", 32'(cyc - de_cyc), 32'd2);
        lat_arm = 1'b0;
      end
      if (cap_valid && cap_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_word", 32'(cap_valid), 32'd0);
        end else begin
          exp_w = exp_q.pop_front();
          check("word", 32'(cur), 32'(exp_w));
        end
      end
      prev_stall = cap_valid && !cap_ready;
      prev_word  = cur;
    end
  end

  task automatic tick();
    @(posedge clk_pix);
    #1;
    cyc++;
    case (mode)
      0:       cap_ready = 1'b1;
      1:       cap_ready = ~cap_ready;
      default: cap_ready = 1'b0;
    endcase
  endtask

  // Strobe, then a raster of npix active pixels; the first `keep` are expected out.
  task automatic send_frame(input bit en, input int npix, input int keep,
                            input int en_off_at, input bit gaps, input bit lat);
    int    idx;
    word_t w;
    cap_en    = en;
    vid_frame = 1'b1;
    vid_de    = 1'b0;
    tick();
    vid_frame = 1'b0;
    idx = 0;
    for (int y = 0; y < V_RES; y++) begin
      for (int x = 0; x < H_RES; x++) begin
        if (idx < npix) begin
          vid_x  = CORDW'(x);
          vid_y  = CORDW'(y);
          vid_de = 1'b1;
          vid_r  = 8'($urandom);
          vid_g  = 8'($urandom);
          vid_b  = 8'($urandom);
          if (idx < keep) begin
            w.sof  = (x == 0) && (y == 0);
            w.eol  = (x == H_RES - 1);
            w.data = {vid_r, vid_g, vid_b};
            exp_q.push_back(w);
          end
          if (lat && idx == 0) begin
            de_cyc  = cyc;
            lat_arm = 1'b1;
          end
        end else begin
          vid_de = 1'b0;
        end
        if (idx == en_off_at) cap_en = 1'b0;
        tick();
        idx++;
        if (gaps) begin
          vid_de = 1'b0;
          tick();
        end
      end
      vid_de = 1'b0;
      tick();
      tick();
    end
    vid_de = 1'b0;
    repeat (3) tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    repeat (2) tick();
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(cap_valid), 32'd0);
    check({tag, "_data"}, 32'({cap_sof, cap_eol, cap_data}), 32'd0);
    check({tag, "_busy"}, 32'(cap_busy), 32'd0);
    check({tag, "_ovf"}, 32'(cap_overflow), 32'd0);
    check({tag, "_geom"}, 32'(geom_err), 32'd0);
    check({tag, "_drops"}, 32'(drop_count), 32'd0);
    check({tag, "_frames"}, 32'(frame_count), 32'd0);
  endtask

  logic exp_geom;

  initial begin
`ifdef CAPTURE_CHECK_EN
    exp_geom = 1'b1;
`else
    exp_geom = 1'b0;
`endif
    rst_pix = 1'b1; cap_en = 1'b0; cap_ready = 1'b1;
    vid_x = '0; vid_y = '0; vid_de = 1'b0; vid_frame = 1'b0;
    vid_r = '0; vid_g = '0; vid_b = '0;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst_pix = 1'b0;

    // basic 4x2 frame with latency measurement
    cap_en = 1'b1;
    repeat (3) tick();
    send_frame(1'b1, 8, 8, -1, 1'b0, 1'b1);
    drain();
    check("t1_frames", 32'(frame_count), 32'd1);
    check("t1_busy", 32'(cap_busy), 32'd1);

    // backpressure: ready toggling every cycle
    mode = 1;
    send_frame(1'b1, 8, 8, -1, 1'b1, 1'b0);
    drain();
    check("t2_frames", 32'(frame_count), 32'd2);

    // overflow with ready held low
    mode = 2;
    tick();
    send_frame(1'b1, 8, 4, -1, 1'b0, 1'b0);
    check("t3_ovf", 32'(cap_overflow), 32'd1);
    check("t3_drops", 32'(drop_count), 32'd4);
    check("t3_busy", 32'(cap_busy), 32'd1);
    check("t3_frames", 32'(frame_count), 32'd3);
    mode = 0;
    drain();
    send_frame(1'b1, 8, 8, -1, 1'b0, 1'b0);
    drain();
    check("t3_recap_frames", 32'(frame_count), 32'd4);
    check("t3_recap_drops", 32'(drop_count), 32'd4);

    // cap_en dropped mid-frame: frame completes, then idle at the next strobe
    send_frame(1'b1, 8, 8, 3, 1'b0, 1'b0);
    drain();
    check("t4_busy_mid", 32'(cap_busy), 32'd1);
    check("t4_frames", 32'(frame_count), 32'd5);
    send_frame(1'b0, 8, 0, -1, 1'b0, 1'b0);
    drain();
    check("t4_busy_after", 32'(cap_busy), 32'd0);
    check("t4_frames_after", 32'(frame_count), 32'd5);
    check("t4_geom", 32'(geom_err), 32'd0);

    // short frame of 7 pixels
    cap_en = 1'b1;
    repeat (3) tick();
    send_frame(1'b1, 7, 7, -1, 1'b0, 1'b0);
    drain();
    check("t5_frames", 32'(frame_count), 32'd6);
    send_frame(1'b0, 0, 0, -1, 1'b0, 1'b0);
    check("t5_geom", 32'(geom_err), 32'(exp_geom));

    // reset mid-frame with words queued
    cap_en = 1'b1;
    repeat (3) tick();
    mode = 2;
    tick();
    send_frame(1'b1, 3, 3, -1, 1'b0, 1'b0);
    check("t6_queued", 32'(cap_valid), 32'd1);
    check("t6_frames", 32'(frame_count), 32'd7);
    rst_pix = 1'b1;
    tick();
    check_idle_outputs("t6_rst");
    exp_q.delete();
    rst_pix = 1'b0;
    cap_en  = 1'b0;
    mode    = 0;
    tick();
    send_frame(1'b0, 8, 0, -1, 1'b0, 1'b0);
    check("t6_no_out", 32'(cap_valid), 32'd0);
    check("t6_no_frame", 32'(frame_count), 32'd0);
    cap_en = 1'b1;
    repeat (3) tick();
    send_frame(1'b1, 8, 8, -1, 1'b0, 1'b0);
    drain();
    check("t6_frames_after", 32'(frame_count), 32'd1);
    check("t6_ovf_after", 32'(cap_overflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary by %0t", $time);
    $fatal(1);
  end

endmodule
